// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage: FSM state, MEM/WB entry
// layout, MemToReg encodings and the default data-memory timeout.
package mem_stage_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    localparam logic [1:0] MTR_ALU = 2'd0;
    localparam logic [1:0] MTR_MEM = 2'd1;
    localparam logic [1:0] MTR_PC4 = 2'd2;

    localparam int unsigned TIMEOUT_CYCLES_DEF = 16;

    typedef struct packed {
        logic [31:0] pc_p4;
        logic [31:0] alu_out;
        logic [31:0] mem_data;
        logic [4:0]  rd;
        logic [1:0]  mem_to_reg;
        logic        reg_write;
    } wb_entry_t;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A bubble clears the entry (so nothing writes back);
// otherwise the entry loads when load_i is high.
module mem_wb_reg
    import mem_stage_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      load_i,
    input  logic      bubble_i,
    input  wb_entry_t entry_i,
    output wb_entry_t entry_o
);

    wb_entry_t entry_q, entry_d;

    always_comb begin
        entry_d = entry_q;
        if (bubble_i) begin
            entry_d = '0;
        end else if (load_i) begin
            entry_d = entry_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign entry_o = entry_q;

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: issues data-memory requests, stalls the pipe while waiting for ack,
// flags misaligned accesses and feeds MEM/WB. Define MEM_ACCESS_TIMEOUT_EN to add
// a wait-cycle watchdog that aborts unacknowledged accesses with bus_err.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [31:0] PC_p4,
    input  logic [31:0] alu_out,
    input  logic [31:0] rt_data,
    input  logic [4:0]  Rd,
    input  logic [1:0]  MemToReg,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic        RegWrite,

    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,

    output logic        stall_req,
    output logic        addr_err,
    output logic        bus_err,

    output logic [31:0] WB_PC_p4,
    output logic [31:0] WB_alu_out,
    output logic [31:0] WB_mem_data,
    output logic [4:0]  WB_Rd,
    output logic [1:0]  WB_MemToReg,
    output logic        WB_RegWrite
);

    mem_state_e state_q, state_d;
    logic       mem_op;
    logic       is_load;
    logic       misaligned;
    logic       timeout_hit;
    wb_entry_t  entry_in;
    wb_entry_t  entry_out;

    assign mem_op     = MemRead | MemWrite;
    assign is_load    = MemRead & ~MemWrite;
    assign misaligned = mem_op & is_misaligned(alu_out);

    assign dmem_addr  = alu_out;
    assign dmem_wdata = rt_data;
    assign dmem_we    = MemWrite;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Held at zero outside WAIT so it starts from zero on every entry to WAIT.
    always_comb begin
        cnt_d = '0;
        if (state_q == ST_WAIT && !dmem_ack) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_hit = (state_q == ST_WAIT) && !dmem_ack &&
                         (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (mem_op && !misaligned && !dmem_ack) state_d = ST_WAIT;
            ST_WAIT: if (dmem_ack || timeout_hit) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Control outputs are forced low while reset is held, whatever the inputs.
    always_comb begin
        dmem_req  = 1'b0;
        stall_req = 1'b0;
        addr_err  = 1'b0;
        bus_err   = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_IDLE: begin
                    if (misaligned) begin
                        addr_err = 1'b1;
                    end else if (mem_op) begin
                        dmem_req  = 1'b1;
                        stall_req = ~dmem_ack;
                    end
                end
                ST_WAIT: begin
                    if (timeout_hit) begin
                        bus_err = 1'b1;
                    end else begin
                        dmem_req  = 1'b1;
                        stall_req = ~dmem_ack;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        entry_in            = '0;
        entry_in.pc_p4      = PC_p4;
        entry_in.alu_out    = alu_out;
        entry_in.mem_data   = is_load ? dmem_rdata : 32'h0;
        entry_in.rd         = Rd;
        entry_in.mem_to_reg = MemToReg;
        entry_in.reg_write  = RegWrite;
    end

    mem_wb_reg u_mem_wb_reg (
        .clk      (clk),
        .reset    (reset),
        .load_i   (~stall_req),
        .bubble_i (stall_req | addr_err | bus_err),
        .entry_i  (entry_in),
        .entry_o  (entry_out)
    );

    assign WB_PC_p4    = entry_out.pc_p4;
    assign WB_alu_out  = entry_out.alu_out;
    assign WB_mem_data = entry_out.mem_data;
    assign WB_Rd       = entry_out.rd;
    assign WB_MemToReg = entry_out.mem_to_reg;
    assign WB_RegWrite = entry_out.reg_write;

endmodule
